branch_predictor_bht: RTL and testbench
=======================================

// Module: branch_predictor_bht
// PURPOSE
//  Dynamic branch predictor for the 5-stage RV32 core (BrPred extension).
//  - IF stage: returns a taken/not-taken guess from a table of 2-bit saturating counters.
//  - ID stage: takes the resolved outcome from the branch comparator. The comparator is
//    fed by the branch_A/branch_B forwarding muxes.
//  - Detects a mispredict, issues the redirect PC and flush, trains the table and keeps
//    performance counters.
// PARAMETERS
//  IDX_W      5      BHT index width; 2**IDX_W entries, indexed by pc[IDX_W+1:2]
//  INIT_STATE 2'b01  counter value after reset (weakly not-taken)
//  CNT_W      16     width of performance counters
// PORTS
//  clk           in   1      core clock
//  rst           in   1      synchronous, active-high reset
//  stall         in   1      pipeline stall (load-use / memory); freezes IF/ID latch, blocks resolve
//  IF_pc         in   32     PC of instruction being fetched
//  IF_branch     in   1      predecode: fetched instruction is a conditional branch
//  IF_target     in   32     predecoded branch target (IF_pc + B-imm)
//  pred_taken    out  1      IF_branch && table[IF_pc idx][1]; combinational
//  pred_pc       out  32     pred_taken ? IF_target : IF_pc+4; combinational
//  ID_branch     in   1      ID instruction is a conditional branch with valid operands
//  ID_taken      in   1      resolved outcome from ID comparator
//  ID_target     in   32     resolved branch target from ID adder
//  mispredict    out  1      combinational; asserted in resolve cycle on wrong guess
//  redirect_pc   out  32     correct next PC; valid when mispredict=1, else 0
//  flush_IF_ID   out  1      == mispredict; kills the instruction fetched on the wrong path
//  br_count      out  CNT_W  resolved branches since reset
//  miss_count    out  CNT_W  mispredicts since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - all 2**IDX_W counters <= INIT_STATE; latch valid <= 0; br_count = miss_count = 0.
//   - Reset mid-operation discards any in-flight prediction; no redirect is issued.
//  IF/ID prediction latch, at posedge:
//   - stall=1: latch holds.
//   - else if mispredict: valid <= 0.
//   - else: {valid, pred, idx, pc4} <= {IF_branch, pred_taken, IF_pc idx, IF_pc+4}.
//  Resolve (combinational):
//   - res = ID_branch && valid && !stall.
//   - mispredict = res && (ID_taken != pred).
//   - redirect_pc = ID_taken ? ID_target : pc4 (0 when !mispredict).
//   - Latency: guess is made in IF and checked one cycle later in ID. Penalty is one
//     flushed slot.
//  Training, at posedge when res:
//   - Counter at latched idx: ID_taken ? sat-inc : sat-dec.
//   - Range 0..3; 3 stays 3 on taken; 0 stays 0 on not-taken.
//  Same-cycle read/update of the same index:
//   - IF reads the old (pre-update) value; there is no bypass.
//   - The new value is visible on the next cycle.
//  stall && ID_branch:
//   - No resolve, no update, no counting.
//   - The branch resolves on the first non-stalled cycle.
//  Perf counters:
//   - br_count +1 on res; miss_count +1 on mispredict.
//   - Both saturate at all-ones.
//  Aliasing:
//   - Entries have no tag; PCs with equal pc[IDX_W+1:2] share a counter (intended).
// TESTING
//  1 rst, then branch at 0x100 taken x3:
//    pred 0 -> mispredict=1, redirect=target, counter 01->10;
//    2nd guess taken, no mispredict; counter saturates at 11.
//  2 counter=11, branch at 0x100 not taken:
//    mispredict=1, redirect_pc=0x104, counter 11->10; next guess still taken.
//  3 stall=1 while ID_branch=1 for 3 cycles:
//    mispredict=0, no counter change, br_count unchanged;
//    resolves correctly on the cycle stall drops.
//  4 IF_pc=0x180 (same idx as 0x100) fetched while 0x100 updates the same cycle:
//    pred_taken reflects the old counter value.
//  5 Mispredict cycle:
//    next-cycle latch valid=0, so the wrong-path ID_branch causes no resolve or update.
//  6 rst asserted with latch valid and ID_branch=1:
//    no mispredict after reset, counters=01, perf counters=0;
//    force br_count to all-ones, then one more branch -> holds all-ones.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit saturating-counter branch history table with IF/ID prediction latch
module branch_predictor_bht #(
    parameter int         IDX_W      = 5,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      IF_pc,
    input  logic             IF_branch,
    input  logic [31:0]      IF_target,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    input  logic             ID_branch,
    input  logic             ID_taken,
    input  logic [31:0]      ID_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int               ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       bht_q [ENTRIES];
    logic             valid_q, valid_d;
    logic             pred_q, pred_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic             res;
    logic [1:0]       ctr_cur, ctr_d;

    // Prediction reads the pre-update table: no bypass from a same-cycle training write.
    always_comb begin
        if_idx     = IF_pc[IDX_W+1:2];
        pred_taken = IF_branch && bht_q[if_idx][1];
        pred_pc    = pred_taken ? IF_target : IF_pc + 32'd4;
    end

    // Reset kills the in-flight prediction, so nothing resolves in the reset cycle.
    always_comb begin
        res         = ID_branch && valid_q && !stall && !rst;
        mispredict  = res && (ID_taken != pred_q);
        flush_IF_ID = mispredict;
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = ID_taken ? ID_target : pc4_q;
        end
    end

    always_comb begin
        ctr_cur = bht_q[idx_q];
        ctr_d   = ctr_cur;
        if (ID_taken && ctr_cur != 2'b11) begin
            ctr_d = ctr_cur + 2'd1;
        end else if (!ID_taken && ctr_cur != 2'b00) begin
            ctr_d = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        pred_d  = pred_q;
        idx_d   = idx_q;
        pc4_d   = pc4_q;
        if (!stall) begin
            if (mispredict) begin
                valid_d = 1'b0;
            end else begin
                valid_d = IF_branch;
                pred_d  = pred_taken;
                idx_d   = if_idx;
                pc4_d   = IF_pc + 32'd4;
            end
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (res && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end
        if (mispredict && miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= INIT_STATE;
            end
        end else if (res) begin
            bht_q[idx_q] <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pred_q     <= 1'b0;
            idx_q      <= '0;
            pc4_q      <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pred_q     <= pred_d;
            idx_q      <= idx_d;
            pc4_q      <= pc4_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_count   = br_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed vector table plus random run against a reference predictor model
module tb_branch_predictor_bht;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ENTRIES = 32;

    logic             clk = 1'b0;
    logic             rst, stall, IF_branch, ID_branch, ID_taken;
    logic [31:0]      IF_pc, IF_target, ID_target;
    logic             pred_taken, mispredict, flush_IF_ID;
    logic [31:0]      pred_pc, redirect_pc;
    logic [CNT_W-1:0] br_count, miss_count;

    branch_predictor_bht #(.IDX_W(5), .INIT_STATE(2'b01), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .IF_pc(IF_pc), .IF_branch(IF_branch), .IF_target(IF_target),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .ID_branch(ID_branch), .ID_taken(ID_taken), .ID_target(ID_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .flush_IF_ID(flush_IF_ID),
        .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a plain array of counters 0..3 and a record of the last fetched guess.
    int          m_cnt [ENTRIES];
    bit          m_valid, m_guess;
    int          m_idx;
    logic [31:0] m_next;
    int          m_br, m_miss;
    bit          e_pred, e_mis;
    logic [31:0] e_ppc, e_redir;

    typedef struct {
        bit rst, stall;
        logic [31:0] if_pc;  bit if_br;  logic [31:0] if_tgt;
        bit id_br, id_tk;    logic [31:0] id_tgt;
        bit x_pred; logic [31:0] x_ppc; bit x_mis; logic [31:0] x_redir;
        int x_br, x_miss;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 1;
        m_valid = 0; m_guess = 0; m_idx = 0; m_next = 0;
        m_br = 0; m_miss = 0;
    endtask

    // Drive one cycle's inputs after the falling edge, then compare outputs with the model.
    task automatic apply(input bit r, input bit s, input logic [31:0] ipc, input bit ib,
                         input logic [31:0] itg, input bit db, input bit dt, input logic [31:0] dtg);
        bit resolve;
        @(negedge clk);
        rst = r; stall = s; IF_pc = ipc; IF_branch = ib; IF_target = itg;
        ID_branch = db; ID_taken = dt; ID_target = dtg;
        #1;
        e_pred  = ib && (m_cnt[idx_of(ipc)] >= 2);
        e_ppc   = e_pred ? itg : ipc + 32'd4;
        resolve = db && m_valid && !s && !r;
        e_mis   = resolve && (dt != m_guess);
        e_redir = e_mis ? (dt ? dtg : m_next) : 32'd0;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pred});
        check("pred_pc", pred_pc, e_ppc);
        check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        check("flush_IF_ID", {31'd0, flush_IF_ID}, {31'd0, e_mis});
        check("redirect_pc", redirect_pc, e_redir);
        check("br_count", 32'(br_count), 32'(m_br));
        check("miss_count", 32'(miss_count), 32'(m_miss));
        if (r) begin
            model_reset();
        end else begin
            if (resolve) begin
                m_cnt[m_idx] = dt ? ((m_cnt[m_idx] < 3) ? m_cnt[m_idx] + 1 : 3)
                                  : ((m_cnt[m_idx] > 0) ? m_cnt[m_idx] - 1 : 0);
                if (m_br < CNT_MAX) m_br++;
                if (e_mis && m_miss < CNT_MAX) m_miss++;
            end
            if (!s) begin
                if (e_mis) m_valid = 0;
                else begin
                    m_valid = ib; m_guess = e_pred; m_idx = idx_of(ipc); m_next = ipc + 32'd4;
                end
            end
        end
    endtask

    task automatic add_vec(input bit r, input bit s, input logic [31:0] ipc, input bit ib,
                           input logic [31:0] itg, input bit db, input bit dt, input logic [31:0] dtg,
                           input bit xp, input logic [31:0] xppc, input bit xm,
                           input logic [31:0] xr, input int xb, input int xmi);
        vec_t v;
        v.rst = r; v.stall = s; v.if_pc = ipc; v.if_br = ib; v.if_tgt = itg;
        v.id_br = db; v.id_tk = dt; v.id_tgt = dtg;
        v.x_pred = xp; v.x_ppc = xppc; v.x_mis = xm; v.x_redir = xr; v.x_br = xb; v.x_miss = xmi;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1; stall = 0; IF_pc = 0; IF_branch = 0; IF_target = 0;
        ID_branch = 0; ID_taken = 0; ID_target = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Taken x3 from weakly not-taken, then a not-taken with a same-index fetch (0x180).
        add_vec(0,0,32'h100,1,32'h200, 0,0,32'h0,   0,32'h104,0,32'h0,   0,0);
        add_vec(0,0,32'h104,0,32'h0,   1,1,32'h200, 0,32'h108,1,32'h200, 0,0);
        add_vec(0,0,32'h100,1,32'h200, 1,1,32'h200, 1,32'h200,0,32'h0,   1,1);
        add_vec(0,0,32'h100,1,32'h200, 1,1,32'h200, 1,32'h200,0,32'h0,   1,1);
        add_vec(0,0,32'h100,1,32'h200, 1,1,32'h200, 1,32'h200,0,32'h0,   2,1);
        add_vec(0,0,32'h180,1,32'h300, 1,0,32'h200, 1,32'h300,1,32'h104, 3,1);
        add_vec(0,0,32'h100,1,32'h200, 0,0,32'h0,   1,32'h200,0,32'h0,   4,2);
        // Stalled resolve for three cycles, then it resolves when stall drops.
        for (int i = 0; i < 3; i++)
            add_vec(0,1,32'h180,1,32'h300, 1,1,32'h200, 1,32'h300,0,32'h0, 4,2);
        add_vec(0,0,32'h204,0,32'h0,   1,1,32'h200, 0,32'h208,0,32'h0,   4,2);
        add_vec(0,0,32'h100,1,32'h200, 0,0,32'h0,   1,32'h200,0,32'h0,   5,2);
        // Reset with a valid latch and ID_branch high.
        add_vec(1,0,32'h100,1,32'h200, 1,1,32'h200, 1,32'h200,0,32'h0,   5,2);
        add_vec(0,0,32'h100,1,32'h200, 1,1,32'h200, 0,32'h104,0,32'h0,   0,0);
        add_vec(0,0,32'h300,0,32'h0,   0,0,32'h0,   0,32'h304,0,32'h0,   0,0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].if_pc, vecs[i].if_br, vecs[i].if_tgt,
                  vecs[i].id_br, vecs[i].id_tk, vecs[i].id_tgt);
            check($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].x_pred});
            check($sformatf("vec%0d pred_pc", i), pred_pc, vecs[i].x_ppc);
            check($sformatf("vec%0d mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].x_mis});
            check($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].x_redir);
            check($sformatf("vec%0d br_count", i), 32'(br_count), 32'(vecs[i].x_br));
            check($sformatf("vec%0d miss_count", i), 32'(miss_count), 32'(vecs[i].x_miss));
        end

        // Random traffic over a few aliasing PCs.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            pc = {22'd0, 8'($urandom_range(0, 63)), 2'b00} + ((i % 3 == 0) ? 32'h80 : 32'h0);
            apply(0, ($urandom_range(0, 3) == 0), pc, ($urandom_range(0, 2) != 0),
                  pc + {20'd0, 10'($urandom_range(0, 255)), 2'b00},
                  ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  {24'd0, 6'($urandom_range(0, 63)), 2'b00});
        end

        // Drive the perf counter into saturation with back-to-back taken branches.
        apply(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < CNT_MAX + 20; i++)
            apply(0, 0, 32'h100, 1, 32'h200, 1, 1, 32'h200);
        @(negedge clk); #1;
        check("sat br_count", 32'(br_count), 32'(CNT_MAX));
        check("sat miss_count", 32'(miss_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
